// File: rtl/alpide_pwrseq_multi.sv
// Multi-channel ALPIDE power-up/reset sequencer. Shared timing registers, per-channel FSMs
// and counters, plus per-channel soft reset-pulse and re-sequence commands under a mask.
module alpide_pwrseq_multi #(
  parameter int NCH = 4,
  parameter int TW  = 16
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           reg_we_i,
  input  logic [7:0]     reg_addr_i,
  input  logic [15:0]    reg_data_i,
  output logic [15:0]    reg_data_o,
  input  logic [NCH-1:0] ldo_en_i,
  output logic [NCH-1:0] rst_o,
  output logic [NCH-1:0] forcezero_o,
  output logic [NCH-1:0] oe_o
);

  typedef enum logic [1:0] {
    ST_OFF      = 2'd0,
    ST_POWERING = 2'd1,
    ST_ON       = 2'd2,
    ST_PULSE    = 2'd3
  } state_t;

  logic [TW-1:0]  r_trst;
  logic [TW-1:0]  r_toen;
  logic [TW-1:0]  r_tzero;
  logic [TW-1:0]  r_tpulse;
  logic [NCH-1:0] r_chen;

  state_t         r_state [NCH];
  state_t         w_next  [NCH];
  logic [TW-1:0]  r_crst  [NCH];
  logic [TW-1:0]  r_coen  [NCH];
  logic [TW-1:0]  r_czero [NCH];
  logic [TW-1:0]  r_cpul  [NCH];
  logic [TW-1:0]  w_crst  [NCH];
  logic [TW-1:0]  w_coen  [NCH];
  logic [TW-1:0]  w_czero [NCH];
  logic [TW-1:0]  w_cpul  [NCH];

  logic [NCH-1:0] w_en;
  logic           w_cmd_we;
  logic [15:0]    w_mask_ext;
  logic [NCH-1:0] w_cmd_mask;
  logic [NCH-1:0] w_cmd_pulse;
  logic [NCH-1:0] w_cmd_reseq;
  logic [15:0]    w_status;

  assign w_en        = ldo_en_i & r_chen;
  assign w_cmd_we    = reg_we_i && (reg_addr_i == 8'h07);
  assign w_mask_ext  = {8'h00, reg_data_i[15:8]};
  assign w_cmd_mask  = w_mask_ext[NCH-1:0] & {NCH{w_cmd_we}};
  assign w_cmd_pulse = w_cmd_mask & {NCH{reg_data_i[0]}};
  assign w_cmd_reseq = w_cmd_mask & {NCH{reg_data_i[1]}};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_trst   <= '1;
      r_toen   <= '1;
      r_tzero  <= '1;
      r_tpulse <= '1;
      r_chen   <= '1;
    end else if (reg_we_i) begin
      case (reg_addr_i)
        8'h02:   r_trst   <= reg_data_i[TW-1:0];
        8'h03:   r_toen   <= reg_data_i[TW-1:0];
        8'h04:   r_tzero  <= reg_data_i[TW-1:0];
        8'h05:   r_tpulse <= reg_data_i[TW-1:0];
        8'h06:   r_chen   <= reg_data_i[NCH-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NCH; i++) begin
      if (rst_i) begin
        r_state[i] <= ST_OFF;
        r_crst[i]  <= '1;
        r_coen[i]  <= '1;
        r_czero[i] <= '1;
        r_cpul[i]  <= '1;
      end else begin
        r_state[i] <= w_next[i];
        r_crst[i]  <= w_crst[i];
        r_coen[i]  <= w_coen[i];
        r_czero[i] <= w_czero[i];
        r_cpul[i]  <= w_cpul[i];
      end
    end
  end

  // Loss of enable overrides every state and every command, both on the pins and the next state.
  always_comb begin
    rst_o       = '1;
    forcezero_o = '1;
    oe_o        = '0;
    for (int i = 0; i < NCH; i++) begin
      w_next[i]  = r_state[i];
      w_crst[i]  = r_crst[i];
      w_coen[i]  = r_coen[i];
      w_czero[i] = r_czero[i];
      w_cpul[i]  = r_cpul[i];
      case (r_state[i])
        ST_OFF: begin
          if (w_en[i]) begin
            w_crst[i]  = r_trst;
            w_coen[i]  = r_toen;
            w_czero[i] = r_tzero;
            w_next[i]  = ST_POWERING;
          end
        end
        ST_POWERING: begin
          rst_o[i]       = (r_crst[i] != '0);
          forcezero_o[i] = (r_czero[i] != '0);
          oe_o[i]        = (r_coen[i] == '0);
          if (r_crst[i] != '0)  w_crst[i]  = r_crst[i] - TW'(1);
          if (r_coen[i] != '0)  w_coen[i]  = r_coen[i] - TW'(1);
          if (r_czero[i] != '0) w_czero[i] = r_czero[i] - TW'(1);
          if (w_cmd_reseq[i]) begin
            w_next[i] = ST_OFF;
          end else if ((r_crst[i] == '0) && (r_coen[i] == '0) && (r_czero[i] == '0)) begin
            w_next[i] = ST_ON;
          end
        end
        ST_ON: begin
          rst_o[i]       = 1'b0;
          forcezero_o[i] = 1'b0;
          oe_o[i]        = 1'b1;
          if (w_cmd_reseq[i]) begin
            w_next[i] = ST_OFF;
          end else if (w_cmd_pulse[i]) begin
            w_cpul[i] = r_tpulse;
            w_next[i] = ST_PULSE;
          end
        end
        ST_PULSE: begin
          rst_o[i]       = 1'b1;
          forcezero_o[i] = 1'b0;
          oe_o[i]        = 1'b1;
          if (w_cmd_reseq[i]) begin
            w_next[i] = ST_OFF;
          end else if (r_cpul[i] == '0) begin
            w_next[i] = ST_ON;
          end else begin
            w_cpul[i] = r_cpul[i] - TW'(1);
          end
        end
        default: w_next[i] = ST_OFF;
      endcase
      if (!w_en[i]) begin
        rst_o[i]       = 1'b1;
        forcezero_o[i] = 1'b1;
        oe_o[i]        = 1'b0;
        w_next[i]      = ST_OFF;
      end
    end
  end

  always_comb begin
    w_status = '0;
    for (int i = 0; i < NCH; i++) begin
      w_status[i] = (r_state[i] == ST_ON);
    end
    reg_data_o = 16'hF001;
    case (reg_addr_i)
      8'h00: reg_data_o = w_status;
      8'h02: reg_data_o = 16'(r_trst);
      8'h03: reg_data_o = 16'(r_toen);
      8'h04: reg_data_o = 16'(r_tzero);
      8'h05: reg_data_o = 16'(r_tpulse);
      8'h06: reg_data_o = 16'(r_chen);
      8'h07: reg_data_o = 16'h0000;
      default: begin
        for (int i = 0; i < NCH; i++) begin
          if (reg_addr_i == 8'(16 + i)) begin
            reg_data_o = {11'b0, r_state[i], rst_o[i], forcezero_o[i], oe_o[i]};
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_alpide_pwrseq_multi.sv
// Bench for alpide_pwrseq_multi: elapsed-time model checked every cycle, plus directed
// literal expectations for the power-up timeline, pulses, enable loss, masking and reset.
module tb_alpide_pwrseq_multi;

  localparam int M_OFF   = 0;
  localparam int M_POW   = 1;
  localparam int M_ON    = 2;
  localparam int M_PULSE = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [7:0]  addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic [3:0]  ldo;
  logic [3:0]  rstO;
  logic [3:0]  fzO;
  logic [3:0]  oeO;

  logic        we4;
  logic [7:0]  addr4;
  logic [15:0] wdata4;
  logic [15:0] rdata4;
  logic [0:0]  ldo4;
  logic [0:0]  rsto4;
  logic [0:0]  fzo4;
  logic [0:0]  oeo4;

  int passChecks  = 0;
  int totalChecks = 0;

  always #5 clk = ~clk;

  alpide_pwrseq_multi #(.NCH(4), .TW(16)) u_dut (
    .clk_i(clk), .rst_i(rst), .reg_we_i(we), .reg_addr_i(addr), .reg_data_i(wdata),
    .reg_data_o(rdata), .ldo_en_i(ldo), .rst_o(rstO), .forcezero_o(fzO), .oe_o(oeO)
  );

  alpide_pwrseq_multi #(.NCH(1), .TW(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .reg_we_i(we4), .reg_addr_i(addr4), .reg_data_i(wdata4),
    .reg_data_o(rdata4), .ldo_en_i(ldo4), .rst_o(rsto4), .forcezero_o(fzo4), .oe_o(oeo4)
  );

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    totalChecks++;
    if (actual === expected) passChecks++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Model: each channel tracks elapsed cycles in its phase rather than down-counters.
  int       mMode [4];
  int       mK    [4];
  int       mLr   [4];
  int       mLo   [4];
  int       mLz   [4];
  int       mP    [4];
  int       mPlen [4];
  int       mTrst, mToen, mTzero, mTpulse;
  logic [3:0] mChen;
  bit       modelValid = 1'b0;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  always @(posedge clk) begin
    bit en, hit;
    if (rst) begin
      for (int c = 0; c < 4; c++) mMode[c] = M_OFF;
      mTrst = 16'hFFFF; mToen = 16'hFFFF; mTzero = 16'hFFFF; mTpulse = 16'hFFFF;
      mChen = 4'hF;
      modelValid = 1'b1;
    end else if (modelValid) begin
      for (int c = 0; c < 4; c++) begin
        en  = ldo[c] & mChen[c];
        hit = we && (addr == 8'h07) && wdata[8+c];
        if (!en) mMode[c] = M_OFF;
        else if (mMode[c] == M_OFF) begin
          mMode[c] = M_POW; mK[c] = 0;
          mLr[c] = mTrst; mLo[c] = mToen; mLz[c] = mTzero;
        end else if (hit && wdata[1]) mMode[c] = M_OFF;
        else if (mMode[c] == M_POW) begin
          if (mK[c] >= max3(mLr[c], mLo[c], mLz[c])) mMode[c] = M_ON;
          else mK[c]++;
        end else if (mMode[c] == M_ON) begin
          if (hit && wdata[0]) begin mMode[c] = M_PULSE; mP[c] = 0; mPlen[c] = mTpulse; end
        end else begin
          if (mP[c] >= mPlen[c]) mMode[c] = M_ON;
          else mP[c]++;
        end
      end
      if (we) begin
        case (addr)
          8'h02: mTrst   = wdata;
          8'h03: mToen   = wdata;
          8'h04: mTzero  = wdata;
          8'h05: mTpulse = wdata;
          8'h06: mChen   = wdata[3:0];
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    logic [3:0] eR, eF, eO;
    if (modelValid) begin
      for (int c = 0; c < 4; c++) begin
        eR[c] = 1'b1; eF[c] = 1'b1; eO[c] = 1'b0;
        if (ldo[c] & mChen[c]) begin
          case (mMode[c])
            M_POW:   begin eR[c] = (mK[c] < mLr[c]); eF[c] = (mK[c] < mLz[c]); eO[c] = (mK[c] >= mLo[c]); end
            M_ON:    begin eR[c] = 1'b0; eF[c] = 1'b0; eO[c] = 1'b1; end
            M_PULSE: begin eR[c] = 1'b1; eF[c] = 1'b0; eO[c] = 1'b1; end
            default: ;
          endcase
        end
      end
      checkOutput("model rst_o", {12'b0, rstO}, {12'b0, eR});
      checkOutput("model forcezero_o", {12'b0, fzO}, {12'b0, eF});
      checkOutput("model oe_o", {12'b0, oeO}, {12'b0, eO});
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic applyStimulus(input logic [7:0] a, input logic [15:0] d);
    addr = a; wdata = d; we = 1'b1;
    tick(1);
    we = 1'b0;
  endtask

  task automatic applyStimulus4(input logic [7:0] a, input logic [15:0] d);
    addr4 = a; wdata4 = d; we4 = 1'b1;
    tick(1);
    we4 = 1'b0;
  endtask

  task automatic regRead(input logic [7:0] a, output logic [15:0] v);
    addr = a; #1; v = rdata;
  endtask

  task automatic regRead4(input logic [7:0] a, output logic [15:0] v);
    addr4 = a; #1; v = rdata4;
  endtask

  logic [15:0] v;
  logic [3:0]  t1Exp [7];

  initial begin
    t1Exp = '{4'b1100, 4'b1100, 4'b1100, 4'b0100, 4'b0000, 4'b0010, 4'b0011};
    rst = 1'b1; we = 1'b0; addr = 8'h00; wdata = 16'h0000; ldo = 4'h0;
    we4 = 1'b0; addr4 = 8'h00; wdata4 = 16'h0000; ldo4 = 1'b0;
    @(posedge clk); #1;
    tick(2);

    // Reset state and register map
    checkOutput("reset pins", {4'b0, rstO, fzO, oeO}, 16'h0FF0);
    regRead(8'h00, v); checkOutput("reset STATUS", v, 16'h0000);
    regRead(8'h02, v); checkOutput("reset TRST", v, 16'hFFFF);
    regRead(8'h06, v); checkOutput("reset CHEN", v, 16'h000F);
    regRead(8'h07, v); checkOutput("CMD read", v, 16'h0000);
    regRead(8'h01, v); checkOutput("unmapped 0x01", v, 16'hF001);
    regRead(8'h14, v); checkOutput("unmapped 0x14", v, 16'hF001);
    regRead(8'h10, v); checkOutput("reset CHSTAT0", v, 16'h0006);
    rst = 1'b0;
    tick(1);

    // Narrow-timer instance: truncated writes and short phases
    regRead4(8'h02, v); checkOutput("TW4 reset TRST", v, 16'h000F);
    applyStimulus4(8'h02, 16'h00F3);
    regRead4(8'h02, v); checkOutput("TW4 TRST readback", v, 16'h0003);
    applyStimulus4(8'h03, 16'h0000);
    applyStimulus4(8'h04, 16'h0000);
    ldo4 = 1'b1;
    tick(1); checkOutput("TW4 rst e1", {15'b0, rsto4}, 16'h0001);
    tick(1); checkOutput("TW4 rst e2", {15'b0, rsto4}, 16'h0001);
    tick(1); checkOutput("TW4 rst e3", {15'b0, rsto4}, 16'h0001);
    tick(1); checkOutput("TW4 rst e4", {15'b0, rsto4}, 16'h0000);
    tick(1); regRead4(8'h10, v); checkOutput("TW4 ON", v, 16'h0011);
    applyStimulus4(8'h02, 16'h0000);
    applyStimulus4(8'h07, 16'h0102);
    regRead4(8'h10, v); checkOutput("TW4 reseq OFF", v, 16'h0006);
    tick(1); regRead4(8'h10, v); checkOutput("TW4 zero POWERING", v, 16'h0009);
    tick(1); regRead4(8'h10, v); checkOutput("TW4 zero ON", v, 16'h0011);

    // Single-channel power-up timeline
    applyStimulus(8'h02, 16'd3);
    applyStimulus(8'h04, 16'd4);
    applyStimulus(8'h03, 16'd5);
    ldo = 4'b0001;
    for (int k = 1; k <= 7; k++) begin
      tick(1);
      regRead(8'h00, v);
      checkOutput($sformatf("T1 edge %0d", k), {12'b0, rstO[0], fzO[0], oeO[0], v[0]},
                  {12'b0, t1Exp[k-1]});
    end
    ldo = 4'hF;
    tick(10);
    regRead(8'h00, v); checkOutput("all ON", v, 16'h000F);

    // Soft reset pulse on ch0 and ch2
    applyStimulus(8'h05, 16'd2);
    applyStimulus(8'h07, 16'h0501);
    checkOutput("pulse c1 rst", {12'b0, rstO}, 16'h0005);
    checkOutput("pulse oe held", {12'b0, oeO}, 16'h000F);
    regRead(8'h10, v); checkOutput("CHSTAT0 PULSE", v, 16'h001D);
    tick(1); checkOutput("pulse c2 rst", {12'b0, rstO}, 16'h0005);
    tick(1); checkOutput("pulse c3 rst", {12'b0, rstO}, 16'h0005);
    tick(1); checkOutput("pulse end rst", {12'b0, rstO}, 16'h0000);

    // Enable loss beats a command in the same cycle
    applyStimulus(8'h07, 16'h0202);
    regRead(8'h11, v); checkOutput("CHSTAT1 reseq OFF", v, 16'h0006);
    tick(6);
    regRead(8'h11, v); checkOutput("CHSTAT1 POWERING k5", v, 16'h0009);
    ldo = 4'b1101; addr = 8'h07; wdata = 16'h0201; we = 1'b1;
    #1;
    checkOutput("ch1 safe now", {13'b0, rstO[1], fzO[1], oeO[1]}, 16'h0006);
    tick(1);
    we = 1'b0;
    regRead(8'h11, v); checkOutput("CHSTAT1 OFF", v, 16'h0006);
    ldo = 4'hF;
    tick(10);

    // Channel enable mask
    ldo = 4'h0;
    tick(2);
    applyStimulus(8'h06, 16'h000E);
    ldo = 4'hF;
    tick(3);
    applyStimulus(8'h07, 16'h0E01);
    tick(8);
    regRead(8'h00, v); checkOutput("CHEN=E STATUS", v, 16'h000E);
    checkOutput("ch0 masked", {13'b0, rstO[0], fzO[0], oeO[0]}, 16'h0006);
    applyStimulus(8'h06, 16'h000F);
    applyStimulus(8'h02, 16'h0001);
    tick(9);
    regRead(8'h00, v); checkOutput("CHEN=F STATUS", v, 16'h000F);

    // Synchronous reset mid-POWERING
    applyStimulus(8'h07, 16'h0F02);
    tick(2);
    rst = 1'b1;
    tick(1);
    checkOutput("rst mid-pow pins", {4'b0, rstO, fzO, oeO}, 16'h0FF0);
    rst = 1'b0; ldo = 4'h0;
    regRead(8'h02, v); checkOutput("rst TRST", v, 16'hFFFF);
    regRead(8'h03, v); checkOutput("rst TOEN", v, 16'hFFFF);
    regRead(8'h04, v); checkOutput("rst TZERO", v, 16'hFFFF);
    regRead(8'h06, v); checkOutput("rst CHEN", v, 16'h000F);
    applyStimulus(8'h02, 16'd2);
    applyStimulus(8'h03, 16'd3);
    applyStimulus(8'h04, 16'd2);
    applyStimulus(8'h05, 16'd5);
    ldo = 4'hF;
    tick(8);
    regRead(8'h00, v); checkOutput("resequenced ON", v, 16'h000F);

    // Synchronous reset during PULSE
    applyStimulus(8'h07, 16'h0F01);
    tick(2);
    regRead(8'h10, v); checkOutput("CHSTAT0 in PULSE", v, 16'h001D);
    rst = 1'b1;
    tick(1);
    checkOutput("rst in pulse pins", {4'b0, rstO, fzO, oeO}, 16'h0FF0);
    regRead(8'h10, v); checkOutput("rst CHSTAT0", v, 16'h0006);
    rst = 1'b0; ldo = 4'h0;
    regRead(8'h05, v); checkOutput("rst TPULSE", v, 16'hFFFF);
    tick(2);

    $display("%0d/%0d checks passed", passChecks, totalChecks);
    $finish;
  end

endmodule
